mem_cycle_seq: RTL and testbench
================================

// Module: mem_cycle_seq
// PURPOSE
//  Parametrised external-memory bus sequencer: runs fetch, load and store cycles
//  on the pad/memory-map strobes (ALE, nME, nOE, nWE, ENB, MemEn) for the core controller.
//  Adds address-setup and wait-state stretching, which the fixed 4-cycle sequence lacks.
//  Sits between the control FSM (request/done handshake) and the pad ring; one access in flight.
// PARAMETERS
//  ADDR_SETUP = 1   ALE-high cycles per access, legal 1..4
//  WAIT_STATES = 0  extra access-hold cycles, legal 0..15
//  TIMEOUT = 63     max nWait-extension cycles before abort (MEM_WAIT_EN only), legal 1..255
// PORTS
//  Clock     in   1  system clock, rising edge
//  nReset    in   1  asynchronous, active-low reset
//  ReqValid  in   1  access request from control FSM
//  ReqKind   in   2  opcodes::mem_kind_t: MemFetch / MemLoad / MemStore
//  ReqReady  out  1  high only in IDLE; request accepted on ReqValid&&ReqReady at rising edge
//  Done      out  1  one-cycle pulse, final cycle of access
//  Error     out  1  one-cycle pulse with Done on timeout abort (0 without MEM_WAIT_EN)
//  PcEn      out  1  PC onto SysBus as address (fetch, ADDR state)
//  AluEn     out  1  ALU reg onto SysBus (load/store address in ADDR; store data in SETUP/WRITE)
//  IrWe      out  1  instruction register write (fetch, LATCH)
//  RegWe     out  1  register-file write from SysBus (load, LATCH)
//  ALE nME nOE nWE ENB MemEn  out 1 each  memory/pad strobes, active levels as named
//  nWait     in   1  memory ready, low = extend (present only with MEM_WAIT_EN)
// BEHAVIOUR
//  - Reset / IDLE: ALE=0 nME=1 nOE=1 nWE=1 ENB=0 MemEn=0, all enables 0, ReqReady=1, Done=Error=0.
//  - Outputs are Moore decode of registered state + kind; async reset forces IDLE values
//    immediately, aborts any access mid-cycle, no Done issued.
//  - Kind is latched on acceptance; ReqKind ignored while busy. ReqValid while busy is ignored (not queued).
//  - Read (fetch/load): ADDR(ALE=1, PcEn or AluEn) x ADDR_SETUP -> ACCESS(nME=0 nOE=0 MemEn=1)
//    x (1+WAIT_STATES) -> STROBE(nME=0 nOE=0 MemEn=1 ENB=1) -> LATCH(nME=1 MemEn=1, IrWe|RegWe, Done) -> IDLE.
//  - Write (store): ADDR x ADDR_SETUP -> SETUP(nME=0 AluEn=1) -> WRITE(nME=0 nWE=0 AluEn=1)
//    x (1+WAIT_STATES) -> RECOVER(all strobes inactive, AluEn=1, Done) -> IDLE.
//  - Latency, acceptance edge to Done cycle inclusive: 3+ADDR_SETUP+WAIT_STATES cycles (4 at defaults).
//  - nOE and nWE never low together; nWE low only inside nME low.
//  - Down-counter width $clog2 of max(ADDR_SETUP, WAIT_STATES+1, TIMEOUT)+1; reloaded on each state entry.
//  - WAIT_STATES=0: ACCESS/WRITE held exactly 1 cycle, counter reaches zero on entry.
// CONFIGURATION
//  MEM_CYCLE_SEQ_WAIT_EN defined: nWait port present, sampled at rising edge in the last
//    ACCESS/WRITE cycle; low holds that state (strobes unchanged). After TIMEOUT extra cycles:
//    skip STROBE, enter LATCH/RECOVER with IrWe=RegWe=0, Done=1 and Error=1.
//  Undefined: no nWait port, fixed timing, Error tied 0.
// STRUCTURE
//  opcodes package: mem_kind_t {MemFetch, MemLoad, MemStore}; mem_state_t {MsIdle, MsAddr,
//    MsAccess, MsStrobe, MsLatch, MsSetup, MsWrite, MsRecover}.
//  Sub-module mem_wait_counter: loadable down-counter with zero flag. Used for setup/wait/timeout.
// TESTING
//  1 defaults, MemFetch pulse: ALE c1; nME=0 c2-c3; ENB c3; IrWe+Done c4; ReqReady back c5.
//  2 defaults, MemStore: AluEn c1-c4; nWE=0 only c3 with nME=0, nOE=1 throughout; Done c4, RegWe never 1.
//  3 ADDR_SETUP=2 WAIT_STATES=2 MemLoad: ALE 2 cycles, ACCESS 3 cycles, RegWe+Done at cycle 7.
//  4 ReqValid held high with alternating kinds during busy: exactly one access, kind of accepted cycle.
//  5 nReset low during STROBE: strobes to idle at once, no IrWe/Done; next request runs normally.
//  6 MEM_CYCLE_SEQ_WAIT_EN, TIMEOUT=3: nWait low 2 cycles -> load completes 2 cycles late; nWait held low
//    -> Done+Error after 3 extra cycles, RegWe=0.

Source files
------------

// File: rtl/mem_cycle_seq_pkg.sv
// Shared types for the external-memory bus sequencer: access kinds, FSM states
// and a small sizing helper for the wait counter.
package opcodes;

  typedef enum logic [1:0] {
    MemFetch = 2'd0,
    MemLoad  = 2'd1,
    MemStore = 2'd2
  } mem_kind_t;

  typedef enum logic [2:0] {
    MsIdle,
    MsAddr,
    MsAccess,
    MsStrobe,
    MsLatch,
    MsSetup,
    MsWrite,
    MsRecover
  } mem_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with zero flag; saturates at zero. Paces address setup,
// wait states and the nWait timeout of the memory sequencer.
module mem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_cycle_seq.sv
// External-memory bus sequencer: fetch/load/store cycles with address setup and
// wait-state stretching. Optional nWait handshake with timeout via MEM_CYCLE_SEQ_WAIT_EN.
module mem_cycle_seq
  import opcodes::*;
#(
  parameter int ADDR_SETUP  = 1,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 63
) (
  input  logic      Clock,
  input  logic      nReset,
  input  logic      ReqValid,
  input  mem_kind_t ReqKind,
  output logic      ReqReady,
  output logic      Done,
  output logic      Error,
  output logic      PcEn,
  output logic      AluEn,
  output logic      IrWe,
  output logic      RegWe,
  output logic      ALE,
  output logic      nME,
  output logic      nOE,
  output logic      nWE,
  output logic      ENB,
`ifdef MEM_CYCLE_SEQ_WAIT_EN
  input  logic      nWait,
`endif
  output logic      MemEn
);

  localparam int CNT_MAX = max3(ADDR_SETUP, WAIT_STATES + 1, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Counter holds "remaining cycles after this one", so load N-1 for an N-cycle state.
  localparam logic [CW-1:0] SETUP_LD = CW'(ADDR_SETUP - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_STATES);

  mem_state_t    state_q, state_d;
  mem_kind_t     kind_q, kind_d;
  logic          cnt_load, cnt_zero;
  logic [CW-1:0] cnt_val;
  logic          err_flag;

`ifdef MEM_CYCLE_SEQ_WAIT_EN
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT - 1);
  logic ext_q, ext_d, err_q, err_d;
  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  mem_wait_counter #(.W(CW)) u_cnt (
    .clk_i  (Clock),
    .rst_ni (nReset),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= MsIdle;
      kind_q  <= MemFetch;
`ifdef MEM_CYCLE_SEQ_WAIT_EN
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
`ifdef MEM_CYCLE_SEQ_WAIT_EN
      ext_q   <= ext_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
`ifdef MEM_CYCLE_SEQ_WAIT_EN
    ext_d    = ext_q;
    err_d    = err_q;
`endif
    case (state_q)
      MsIdle: begin
`ifdef MEM_CYCLE_SEQ_WAIT_EN
        err_d = 1'b0;
`endif
        if (ReqValid) begin
          kind_d   = ReqKind;
          state_d  = MsAddr;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      MsAddr: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (kind_q == MemStore) begin
            state_d = MsSetup;
          end else begin
            state_d = MsAccess;
            cnt_val = WAIT_LD;
          end
        end
      end
      MsSetup: begin
        state_d  = MsWrite;
        cnt_load = 1'b1;
        cnt_val  = WAIT_LD;
      end
      MsAccess, MsWrite: begin
`ifdef MEM_CYCLE_SEQ_WAIT_EN
        // Once extending, the counter times out the nWait stall instead of wait states.
        if (ext_q || cnt_zero) begin
          if (nWait) begin
            state_d = (state_q == MsAccess) ? MsStrobe : MsRecover;
            ext_d   = 1'b0;
          end else if (!ext_q) begin
            ext_d    = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = TO_LD;
          end else if (cnt_zero) begin
            state_d = (state_q == MsAccess) ? MsLatch : MsRecover;
            ext_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
`else
        if (cnt_zero) begin
          state_d = (state_q == MsAccess) ? MsStrobe : MsRecover;
        end
`endif
      end
      MsStrobe:            state_d = MsLatch;
      MsLatch, MsRecover:  state_d = MsIdle;
      default:             state_d = MsIdle;
    endcase
  end

  always_comb begin
    ReqReady = 1'b0;
    Done     = 1'b0;
    Error    = 1'b0;
    PcEn     = 1'b0;
    AluEn    = 1'b0;
    IrWe     = 1'b0;
    RegWe    = 1'b0;
    ALE      = 1'b0;
    nME      = 1'b1;
    nOE      = 1'b1;
    nWE      = 1'b1;
    ENB      = 1'b0;
    MemEn    = 1'b0;
    case (state_q)
      MsIdle: ReqReady = 1'b1;
      MsAddr: begin
        ALE   = 1'b1;
        PcEn  = (kind_q == MemFetch);
        AluEn = (kind_q != MemFetch);
      end
      MsAccess: begin
        nME   = 1'b0;
        nOE   = 1'b0;
        MemEn = 1'b1;
      end
      MsStrobe: begin
        nME   = 1'b0;
        nOE   = 1'b0;
        MemEn = 1'b1;
        ENB   = 1'b1;
      end
      MsLatch: begin
        MemEn = 1'b1;
        IrWe  = (kind_q == MemFetch) && !err_flag;
        RegWe = (kind_q == MemLoad) && !err_flag;
        Done  = 1'b1;
        Error = err_flag;
      end
      MsSetup: begin
        nME   = 1'b0;
        AluEn = 1'b1;
      end
      MsWrite: begin
        nME   = 1'b0;
        nWE   = 1'b0;
        AluEn = 1'b1;
      end
      MsRecover: begin
        AluEn = 1'b1;
        Done  = 1'b1;
        Error = err_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_cycle_seq.sv
// Directed bench for mem_cycle_seq: default-timing and stretched instances, cycle-by-cycle
// strobe vectors; nWait/timeout steps run when MEM_CYCLE_SEQ_WAIT_EN is defined.
module tb_mem_cycle_seq;
  import opcodes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst_n = 1'b0;
  logic      rv_d = 1'b0, rv_b = 1'b0;
  mem_kind_t k_d = MemFetch, k_b = MemFetch;
  logic      nwait_d = 1'b1, nwait_b = 1'b1;

  logic rr_d, dn_d, er_d, pc_d, alu_d, ir_d, rw_d, ale_d, nme_d, noe_d, nwe_d, enb_d, men_d;
  logic rr_b, dn_b, er_b, pc_b, alu_b, ir_b, rw_b, ale_b, nme_b, noe_b, nwe_b, enb_b, men_b;

  // Bit order: ReqReady ALE nME nOE nWE ENB MemEn PcEn AluEn IrWe RegWe Done Error
  logic [12:0] obs_d, obs_b;
  assign obs_d = {rr_d, ale_d, nme_d, noe_d, nwe_d, enb_d, men_d, pc_d, alu_d, ir_d, rw_d, dn_d, er_d};
  assign obs_b = {rr_b, ale_b, nme_b, noe_b, nwe_b, enb_b, men_b, pc_b, alu_b, ir_b, rw_b, dn_b, er_b};

  localparam logic [12:0] IDLE_V = 13'b1_0_1_1_1_0_0_0_0_0_0_0_0;
  localparam logic [12:0] F_ADDR = 13'b0_1_1_1_1_0_0_1_0_0_0_0_0;
  localparam logic [12:0] A_ADDR = 13'b0_1_1_1_1_0_0_0_1_0_0_0_0;
  localparam logic [12:0] R_ACC  = 13'b0_0_0_0_1_0_1_0_0_0_0_0_0;
  localparam logic [12:0] R_STB  = 13'b0_0_0_0_1_1_1_0_0_0_0_0_0;
  localparam logic [12:0] F_LAT  = 13'b0_0_1_1_1_0_1_0_0_1_0_1_0;
  localparam logic [12:0] L_LAT  = 13'b0_0_1_1_1_0_1_0_0_0_1_1_0;
  localparam logic [12:0] S_SET  = 13'b0_0_0_1_1_0_0_0_1_0_0_0_0;
  localparam logic [12:0] S_WR   = 13'b0_0_0_1_0_0_0_0_1_0_0_0_0;
  localparam logic [12:0] S_REC  = 13'b0_0_1_1_1_0_0_0_1_0_0_1_0;
`ifdef MEM_CYCLE_SEQ_WAIT_EN
  localparam logic [12:0] L_ABT  = 13'b0_0_1_1_1_0_1_0_0_0_0_1_1;
`endif

  int tests = 0;
  int fails = 0;

  mem_cycle_seq #(.ADDR_SETUP(1), .WAIT_STATES(0), .TIMEOUT(3)) u_d (
    .Clock(clk), .nReset(rst_n), .ReqValid(rv_d), .ReqKind(k_d), .ReqReady(rr_d),
    .Done(dn_d), .Error(er_d), .PcEn(pc_d), .AluEn(alu_d), .IrWe(ir_d), .RegWe(rw_d),
    .ALE(ale_d), .nME(nme_d), .nOE(noe_d), .nWE(nwe_d), .ENB(enb_d),
`ifdef MEM_CYCLE_SEQ_WAIT_EN
    .nWait(nwait_d),
`endif
    .MemEn(men_d)
  );

  mem_cycle_seq #(.ADDR_SETUP(2), .WAIT_STATES(2), .TIMEOUT(63)) u_b (
    .Clock(clk), .nReset(rst_n), .ReqValid(rv_b), .ReqKind(k_b), .ReqReady(rr_b),
    .Done(dn_b), .Error(er_b), .PcEn(pc_b), .AluEn(alu_b), .IrWe(ir_b), .RegWe(rw_b),
    .ALE(ale_b), .nME(nme_b), .nOE(noe_b), .nWE(nwe_b), .ENB(enb_b),
`ifdef MEM_CYCLE_SEQ_WAIT_EN
    .nWait(nwait_b),
`endif
    .MemEn(men_b)
  );

  task automatic chk(input string tag, input logic [12:0] observed, input logic [12:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_d(input string tag, input logic [12:0] expected);
    tick();
    chk(tag, obs_d, expected);
  endtask

  task automatic step_b(input string tag, input logic [12:0] expected);
    tick();
    chk(tag, obs_b, expected);
  endtask

  initial begin
    // Reset state, asynchronous assertion
    #12;
    chk("reset_d", obs_d, IDLE_V);
    chk("reset_b", obs_b, IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_d", obs_d, IDLE_V);

    // 1: fetch, single-cycle request pulse
    rv_d = 1'b1; k_d = MemFetch;
    step_d("fetch_c1", F_ADDR);
    rv_d = 1'b0;
    step_d("fetch_c2", R_ACC);
    step_d("fetch_c3", R_STB);
    step_d("fetch_c4", F_LAT);
    step_d("fetch_c5", IDLE_V);

    // 2: store
    rv_d = 1'b1; k_d = MemStore;
    step_d("store_c1", A_ADDR);
    rv_d = 1'b0;
    step_d("store_c2", S_SET);
    step_d("store_c3", S_WR);
    step_d("store_c4", S_REC);
    step_d("store_c5", IDLE_V);

    // 3: stretched load, ADDR_SETUP=2 WAIT_STATES=2
    rv_b = 1'b1; k_b = MemLoad;
    step_b("slow_c1", A_ADDR);
    rv_b = 1'b0;
    step_b("slow_c2", A_ADDR);
    step_b("slow_c3", R_ACC);
    step_b("slow_c4", R_ACC);
    step_b("slow_c5", R_ACC);
    step_b("slow_c6", R_STB);
    step_b("slow_c7", L_LAT);
    step_b("slow_c8", IDLE_V);

    // 4: request held high with changing kind while busy
    rv_d = 1'b1; k_d = MemStore;
    step_d("hold_c1", A_ADDR);
    k_d = MemFetch;
    step_d("hold_c2", S_SET);
    k_d = MemLoad;
    step_d("hold_c3", S_WR);
    k_d = MemFetch;
    step_d("hold_c4", S_REC);
    rv_d = 1'b0;
    step_d("hold_c5", IDLE_V);
    step_d("hold_c6", IDLE_V);

    // 5: reset asserted during STROBE
    rv_d = 1'b1; k_d = MemFetch;
    step_d("abort_c1", F_ADDR);
    rv_d = 1'b0;
    step_d("abort_c2", R_ACC);
    step_d("abort_c3", R_STB);
    rst_n = 1'b0;
    #1;
    chk("abort_async", obs_d, IDLE_V);
    step_d("abort_held", IDLE_V);
    #2;
    rst_n = 1'b1;
    step_d("abort_after", IDLE_V);
    rv_d = 1'b1; k_d = MemLoad;
    step_d("rerun_c1", A_ADDR);
    rv_d = 1'b0;
    step_d("rerun_c2", R_ACC);
    step_d("rerun_c3", R_STB);
    step_d("rerun_c4", L_LAT);
    step_d("rerun_c5", IDLE_V);

`ifdef MEM_CYCLE_SEQ_WAIT_EN
    // 6a: nWait low for two cycles delays the load by two cycles
    rv_d = 1'b1; k_d = MemLoad;
    step_d("wait_c1", A_ADDR);
    rv_d = 1'b0;
    nwait_d = 1'b0;
    step_d("wait_c2", R_ACC);
    step_d("wait_c3", R_ACC);
    step_d("wait_c4", R_ACC);
    nwait_d = 1'b1;
    step_d("wait_c5", R_STB);
    step_d("wait_c6", L_LAT);
    step_d("wait_c7", IDLE_V);

    // 6b: nWait held low times out after three extra cycles
    rv_d = 1'b1; k_d = MemLoad;
    step_d("tmo_c1", A_ADDR);
    rv_d = 1'b0;
    nwait_d = 1'b0;
    step_d("tmo_c2", R_ACC);
    step_d("tmo_c3", R_ACC);
    step_d("tmo_c4", R_ACC);
    step_d("tmo_c5", R_ACC);
    step_d("tmo_c6", L_ABT);
    nwait_d = 1'b1;
    step_d("tmo_c7", IDLE_V);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
